rtc_hms_counter: RTL and testbench

- Downstream consumer of the 1 Hz divider output `clk1`.
- Keeps time of day as packed BCD hours:minutes:seconds, 24-hour format, counting on each rising edge of `clk1`.
- Runs entirely in the fast `clock` domain; `clk1` is treated as a data input, never as a clock.
- Provides a validated time-load port and single-cycle rollover strobes for downstream display/alarm stages.

---
 rtl/rtc_hms_counter_pkg.sv | 28 ++
 rtl/bcd_mod_counter.sv | 44 ++++
 rtl/rtc_hms_counter.sv | 130 +++++++++++++
 tb/tb_rtc_hms_counter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_hms_counter_pkg.sv
// Shared definitions for the BCD time-of-day counter: range limits, the
// packed time record and small BCD helpers.
package rtc_hms_counter_pkg;

   localparam logic [7:0] SEC_MAX = 8'h59;
   localparam logic [7:0] MIN_MAX = 8'h59;
   localparam logic [7:0] HR_MAX  = 8'h23;

   typedef struct packed {
      logic [7:0] hr;
      logic [7:0] min;
      logic [7:0] sec;
   } hms_t;

   // Both nibbles must be decimal digits; the BCD value then compares
   // numerically like plain binary against a BCD limit.
   function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] limit);
      return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= limit);
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] val);
      if (val[3:0] >= 4'd9) begin
         return {val[7:4] + 4'd1, 4'h0};
      end
      return val + 8'd1;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter: counts 00..MAX_VAL, wraps to 00 and flags the
// wrap combinationally so the next stage can be chained from it.
module bcd_mod_counter
   import rtc_hms_counter_pkg::*;
#(
   parameter logic [7:0] MAX_VAL  = 8'h59,
   parameter logic [7:0] INIT_VAL = 8'h00
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       wrap
);

   logic [7:0] value_q;
   logic [7:0] value_d;
   logic       at_max;

   // Load wins over increment so a loaded value is never advanced.
   always_comb begin
      at_max  = (value_q == MAX_VAL);
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (inc) begin
         value_d = at_max ? 8'h00 : bcd_inc(value_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         value_q <= INIT_VAL;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign wrap  = inc & ~load & at_max;

endmodule

// File: rtl/rtc_hms_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by rising edges of the 1 Hz
// clk1 signal, sampled as data in the clock domain, with validated load.
module rtc_hms_counter
   import rtc_hms_counter_pkg::*;
#(
   parameter bit         SYNC_EN  = 1'b0,
   parameter logic [7:0] INIT_HR  = 8'h00,
   parameter logic [7:0] INIT_MIN = 8'h00,
   parameter logic [7:0] INIT_SEC = 8'h00
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       clk1,
   input  logic       load,
   input  logic [7:0] load_hr,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   output logic       load_err,
   output logic [7:0] hr,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic       sec_tick,
   output logic       min_tick,
   output logic       hr_tick,
   output logic       day_tick
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic s, s_q, s_d;
   logic rise;
   logic count;

   hms_t load_time;
   logic load_valid;
   logic load_ok;

   logic sec_wrap, min_wrap, hr_wrap;

   logic sec_tick_q, sec_tick_d;
   logic min_tick_q, min_tick_d;
   logic hr_tick_q,  hr_tick_d;
   logic day_tick_q, day_tick_d;
   logic load_err_q, load_err_d;

   // History keeps tracking clk1 while disabled, so a rise seen with enable
   // low is consumed rather than replayed later.
   always_comb begin
      sync1_d    = clk1;
      sync2_d    = sync1_q;
      s          = SYNC_EN ? sync2_q : clk1;
      s_d        = s;
      rise       = s & ~s_q;
      count      = rise & enable & ~load;
      load_time  = '{hr: load_hr, min: load_min, sec: load_sec};
      load_valid = bcd_valid(load_time.hr,  HR_MAX)  &
                   bcd_valid(load_time.min, MIN_MAX) &
                   bcd_valid(load_time.sec, SEC_MAX);
      load_ok    = load & load_valid;
      load_err_d = load & ~load_valid;
   end

   // Each carry stage only fires when the stage below wraps this cycle.
   always_comb begin
      sec_tick_d = count;
      min_tick_d = sec_wrap;
      hr_tick_d  = min_wrap;
      day_tick_d = hr_wrap;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         s_q        <= 1'b0;
         sec_tick_q <= 1'b0;
         min_tick_q <= 1'b0;
         hr_tick_q  <= 1'b0;
         day_tick_q <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         s_q        <= s_d;
         sec_tick_q <= sec_tick_d;
         min_tick_q <= min_tick_d;
         hr_tick_q  <= hr_tick_d;
         day_tick_q <= day_tick_d;
         load_err_q <= load_err_d;
      end
   end

   bcd_mod_counter #(.MAX_VAL(SEC_MAX), .INIT_VAL(INIT_SEC)) u_sec (
      .clock    (clock),
      .reset    (reset),
      .inc      (count),
      .load     (load_ok),
      .load_val (load_sec),
      .value    (sec),
      .wrap     (sec_wrap)
   );

   bcd_mod_counter #(.MAX_VAL(MIN_MAX), .INIT_VAL(INIT_MIN)) u_min (
      .clock    (clock),
      .reset    (reset),
      .inc      (sec_wrap),
      .load     (load_ok),
      .load_val (load_min),
      .value    (min),
      .wrap     (min_wrap)
   );

   bcd_mod_counter #(.MAX_VAL(HR_MAX), .INIT_VAL(INIT_HR)) u_hr (
      .clock    (clock),
      .reset    (reset),
      .inc      (min_wrap),
      .load     (load_ok),
      .load_val (load_hr),
      .value    (hr),
      .wrap     (hr_wrap)
   );

   assign sec_tick = sec_tick_q;
   assign min_tick = min_tick_q;
   assign hr_tick  = hr_tick_q;
   assign day_tick = day_tick_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Scoreboard bench for rtc_hms_counter: a seconds-of-day model predicts every
// tick/error pulse and a monitor checks each pulse the DUT produces.
module tb_rtc_hms_counter;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       clk1;
   logic       load;
   logic [7:0] load_hr, load_min, load_sec;
   logic       load_err;
   logic [7:0] hr, min, sec;
   logic       sec_tick, min_tick, hr_tick, day_tick;

   int checks = 0;
   int errors = 0;
   int tick_cnt = 0;
   int sod = 0;
   logic [28:0] exp_q[$];
   logic [28:0] mon_act, mon_exp;

   rtc_hms_counter #(.SYNC_EN(1'b0)) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .clk1     (clk1),
      .load     (load),
      .load_hr  (load_hr),
      .load_min (load_min),
      .load_sec (load_sec),
      .load_err (load_err),
      .hr       (hr),
      .min      (min),
      .sec      (sec),
      .sec_tick (sec_tick),
      .min_tick (min_tick),
      .hr_tick  (hr_tick),
      .day_tick (day_tick)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d events pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] to_bcd(input int n);
      logic [7:0] r;
      r[7:4] = 4'(n / 10);
      r[3:0] = 4'(n % 10);
      return r;
   endfunction

   function automatic logic [28:0] make_rec(input int t, input logic st, input logic mt,
                                            input logic ht, input logic dt, input logic err);
      return {to_bcd(t / 3600), to_bcd((t / 60) % 60), to_bcd(t % 60), st, mt, ht, dt, err};
   endfunction

   // Monitor: every output pulse must match the oldest predicted event.
   always @(negedge clock) begin
      if (sec_tick | min_tick | hr_tick | day_tick | load_err) begin
         mon_act = {hr, min, sec, sec_tick, min_tick, hr_tick, day_tick, load_err};
         if (sec_tick) tick_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected output %h (hr min sec st mt ht dt err)", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               errors++;
               $display("FAIL event: got %h expected %h", mon_act, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic chk_model(input string name);
      chk(name, {8'h00, hr, min, sec}, {8'h00, to_bcd(sod / 3600), to_bcd((sod / 60) % 60), to_bcd(sod % 60)});
   endtask

   task automatic do_rise();
      @(negedge clock);
      clk1 = 1'b1;
      if (enable) begin
         sod = (sod + 1) % 86400;
         exp_q.push_back(make_rec(sod, 1'b1, sod % 60 == 0, sod % 3600 == 0, sod == 0, 1'b0));
      end
      repeat ($urandom_range(1, 4)) @(negedge clock);
      clk1 = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
   endtask

   function automatic bit model_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      int hv, mv, sv;
      hv = int'(h[7:4]) * 10 + int'(h[3:0]);
      mv = int'(m[7:4]) * 10 + int'(m[3:0]);
      sv = int'(s[7:4]) * 10 + int'(s[3:0]);
      if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 || s[7:4] > 9 || s[3:0] > 9)
         return 1'b0;
      if (hv > 23 || mv > 59 || sv > 59)
         return 1'b0;
      sod = hv * 3600 + mv * 60 + sv;
      return 1'b1;
   endfunction

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      @(negedge clock);
      load = 1'b1;
      load_hr = h;
      load_min = m;
      load_sec = s;
      if (!model_load(h, m, s))
         exp_q.push_back(make_rec(sod, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      @(negedge clock);
      load = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      clk1 = 1'b0;
      load = 1'b0;
      load_hr = 8'h00;
      load_min = 8'h00;
      load_sec = 8'h00;

      // Reset held 100 ns with clk1 toggling; no pulses may appear.
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         clk1 = (i % 3 != 2) ? ~clk1 : clk1;
         enable = (i > 4);
      end
      clk1 = 1'b0;
      @(negedge clock);
      chk("reset_time", {8'h00, hr, min, sec}, 32'h0000_0000);
      chk("reset_ticks", {27'd0, sec_tick, min_tick, hr_tick, day_tick, load_err}, 32'd0);
      reset = 1'b0;
      enable = 1'b1;
      sod = 0;

      repeat (5) do_rise();
      @(negedge clock);
      chk("five_rises_time", {8'h00, hr, min, sec}, 32'h0000_0005);
      chk("five_sec_ticks", tick_cnt, 32'd5);

      do_load(8'h00, 8'h00, 8'h08);
      chk("load_000008", {8'h00, hr, min, sec}, 32'h0000_0008);
      repeat (2) do_rise();
      chk("carry_09_10", {8'h00, hr, min, sec}, 32'h0000_0010);

      do_load(8'h00, 8'h00, 8'h59);
      do_rise();
      chk("minute_wrap", {8'h00, hr, min, sec}, 32'h0000_0100);

      do_load(8'h09, 8'h59, 8'h59);
      do_rise();
      chk("hour_09_10", {8'h00, hr, min, sec}, 32'h0010_0000);
      do_load(8'h19, 8'h59, 8'h59);
      do_rise();
      chk("hour_19_20", {8'h00, hr, min, sec}, 32'h0020_0000);

      do_load(8'h23, 8'h59, 8'h58);
      do_rise();
      chk("day_235959", {8'h00, hr, min, sec}, 32'h0023_5959);
      do_rise();
      chk("day_rollover", {8'h00, hr, min, sec}, 32'h0000_0000);

      do_load(8'h24, 8'h00, 8'h00);
      do_load(8'h12, 8'h60, 8'h00);
      do_load(8'h12, 8'h00, 8'h1A);
      @(negedge clock);
      chk("invalid_hold", {8'h00, hr, min, sec}, 32'h0000_0000);
      do_load(8'h12, 8'h34, 8'h56);
      chk("valid_123456", {8'h00, hr, min, sec}, 32'h0012_3456);

      // Load on the exact cycle the rise is seen: load wins, no tick.
      @(negedge clock);
      clk1 = 1'b1;
      load = 1'b1;
      load_hr = 8'h10;
      load_min = 8'h00;
      load_sec = 8'h00;
      sod = 36000;
      @(negedge clock);
      load = 1'b0;
      chk("collision_load", {8'h00, hr, min, sec}, 32'h0010_0000);
      repeat (2) @(negedge clock);
      clk1 = 1'b0;
      @(negedge clock);
      do_rise();
      chk("collision_next", {8'h00, hr, min, sec}, 32'h0010_0001);

      @(negedge clock);
      enable = 1'b0;
      repeat (3) do_rise();
      chk("enable_frozen", {8'h00, hr, min, sec}, 32'h0010_0001);
      @(negedge clock);
      enable = 1'b1;
      do_rise();
      chk("reenable_plus1", {8'h00, hr, min, sec}, 32'h0010_0002);

      // Reset at 00:00:30 coinciding with a clk1 rise.
      do_load(8'h00, 8'h00, 8'h30);
      @(negedge clock);
      reset = 1'b1;
      clk1 = 1'b1;
      sod = 0;
      @(negedge clock);
      chk("midrun_reset", {8'h00, hr, min, sec, 4'h0, sec_tick, min_tick, hr_tick, day_tick},
          {8'h00, 24'h00_0000});
      clk1 = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      do_rise();
      chk("after_reset_rise", {8'h00, hr, min, sec}, 32'h0000_0001);

      // Randomised mix of rises, loads (valid and garbage) and enable flips.
      for (int i = 0; i < 400; i++) begin
         int sel;
         sel = $urandom_range(0, 19);
         if (sel == 0) begin
            int t;
            t = $urandom_range(0, 86399);
            do_load(to_bcd(t / 3600), to_bcd((t / 60) % 60), to_bcd(t % 60));
         end else if (sel == 1) begin
            do_load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 120)), 8'($urandom_range(0, 120)));
         end else if (sel == 2) begin
            do_load(8'h23, 8'h59, 8'($urandom_range(8'h50, 8'h59)));
         end else if (sel == 3) begin
            @(negedge clock);
            enable = ~enable;
         end else begin
            do_rise();
         end
      end
      @(negedge clock);
      chk_model("random_final_time");

      repeat (5) @(negedge clock);
      chk("events_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
